regfile_wb_queue: RTL and testbench

- Writer-side companion to the 32x64 register file. Collects results from the execute (ALU) and memory writeback sources into a 4-entry FIFO.
- Drains one entry per cycle onto the register file write port (RegWrite/writereg/writedata).
- Provides newest-match forwarding of queued-but-unwritten values to the decode read ports, and back-pressures the pipeline when close to full.

---
 rtl/regfile_wb_queue.sv | 115 +++++++++++
 tb/tb_regfile_wb_queue.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_queue.sv
// Writeback queue feeding the register file write port. It merges load and ALU results,
// forwards queued values to decode and raises stall when the queue is nearly full.
module regfile_wb_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 5,
  parameter int DW    = 64
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         alu_valid,
  input  logic [AW-1:0]                alu_reg,
  input  logic [DW-1:0]                alu_data,
  input  logic                         mem_valid,
  input  logic [AW-1:0]                mem_reg,
  input  logic [DW-1:0]                mem_data,
  output logic                         stall,
  output logic                         RegWrite,
  output logic [AW-1:0]                writereg,
  output logic [DW-1:0]                writedata,
  input  logic [AW-1:0]                readreg1,
  input  logic [AW-1:0]                readreg2,
  output logic                         fwd_hit1,
  output logic [DW-1:0]                fwd_data1,
  output logic                         fwd_hit2,
  output logic [DW-1:0]                fwd_data2,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [AW-1:0] entReg_q  [DEPTH];
  logic [DW-1:0] entData_q [DEPTH];
  logic [PW-1:0] rdPtr_q, rdPtr_d;
  logic [PW-1:0] wrPtr_q, wrPtr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;

  logic          pop;
  logic          memAcc;
  logic          aluAcc;
  logic [CW-1:0] freeSlots;

  // The head retires every cycle it exists, so its slot is free for pushes on the same edge.
  always_comb begin
    pop        = (count_q != '0);
    freeSlots  = CW'(DEPTH) - count_q + CW'(pop);
    memAcc     = mem_valid && (freeSlots != '0);
    aluAcc     = alu_valid && (freeSlots > CW'(memAcc));
    rdPtr_d    = rdPtr_q + PW'(pop);
    wrPtr_d    = wrPtr_q + PW'(memAcc) + PW'(aluAcc);
    count_d    = count_q - CW'(pop) + CW'(memAcc) + CW'(aluAcc);
    overflow_d = overflow_q || (mem_valid && !memAcc) || (alu_valid && !aluAcc);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdPtr_q    <= '0;
      wrPtr_q    <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      rdPtr_q    <= rdPtr_d;
      wrPtr_q    <= wrPtr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Entry storage needs no reset; validity comes from the pointers and count.
  always_ff @(posedge clk) begin
    if (rst_n && memAcc) begin
      entReg_q[wrPtr_q]  <= mem_reg;
      entData_q[wrPtr_q] <= mem_data;
    end
    if (rst_n && aluAcc) begin
      entReg_q[wrPtr_q + PW'(memAcc)]  <= alu_reg;
      entData_q[wrPtr_q + PW'(memAcc)] <= alu_data;
    end
  end

  always_comb begin
    RegWrite  = pop;
    writereg  = pop ? entReg_q[rdPtr_q]  : '0;
    writedata = pop ? entData_q[rdPtr_q] : '0;
    stall     = (CW'(DEPTH) - count_q) < CW'(2);
    count     = count_q;
    overflow  = overflow_q;
  end

  // Walk oldest to newest so a later match overrides an earlier one.
  always_comb begin
    logic [PW-1:0] idx;
    fwd_hit1  = 1'b0;
    fwd_data1 = '0;
    fwd_hit2  = 1'b0;
    fwd_data2 = '0;
    idx       = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = rdPtr_q + PW'(k);
      if (CW'(k) < count_q) begin
        if (entReg_q[idx] == readreg1) begin
          fwd_hit1  = 1'b1;
          fwd_data1 = entData_q[idx];
        end
        if (entReg_q[idx] == readreg2) begin
          fwd_hit2  = 1'b1;
          fwd_data2 = entData_q[idx];
        end
      end
    end
  end

endmodule

// File: tb/tb_regfile_wb_queue.sv
// Directed bench for regfile_wb_queue: each step drives inputs, crosses one rising edge,
// then compares outputs against hand-computed values.
module tb_regfile_wb_queue;

  logic        clk;
  logic        rst_n;
  logic        alu_valid;
  logic [4:0]  alu_reg;
  logic [63:0] alu_data;
  logic        mem_valid;
  logic [4:0]  mem_reg;
  logic [63:0] mem_data;
  logic        stall;
  logic        RegWrite;
  logic [4:0]  writereg;
  logic [63:0] writedata;
  logic [4:0]  readreg1;
  logic [4:0]  readreg2;
  logic        fwd_hit1;
  logic [63:0] fwd_data1;
  logic        fwd_hit2;
  logic [63:0] fwd_data2;
  logic [2:0]  count;
  logic        overflow;

  int errors = 0;
  int checks = 0;

  regfile_wb_queue #(.DEPTH(4), .AW(5), .DW(64)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_reg(alu_reg), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_reg(mem_reg), .mem_data(mem_data),
    .stall(stall), .RegWrite(RegWrite), .writereg(writereg), .writedata(writedata),
    .readreg1(readreg1), .readreg2(readreg2),
    .fwd_hit1(fwd_hit1), .fwd_data1(fwd_data1),
    .fwd_hit2(fwd_hit2), .fwd_data2(fwd_data2),
    .count(count), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] simulation did not finish");
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Drive both sources (valid bits may be 0), cross one rising edge, settle outputs.
  task automatic applyStimulus(input logic mv, input logic [4:0] mr, input logic [63:0] md,
                               input logic av, input logic [4:0] ar, input logic [63:0] ad);
    mem_valid = mv; mem_reg = mr; mem_data = md;
    alu_valid = av; alu_reg = ar; alu_data = ad;
    @(posedge clk);
    #1;
    mem_valid = 1'b0;
    alu_valid = 1'b0;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 64'h0);
  endtask

  initial begin
    rst_n = 1'b0;
    alu_valid = 1'b0; alu_reg = '0; alu_data = '0;
    mem_valid = 1'b0; mem_reg = '0; mem_data = '0;
    readreg1 = '0; readreg2 = '0;
    idle();
    idle();
    rst_n = 1'b1;
    #1;
    checkOutput("rst_regwrite", 64'(RegWrite), 64'd0);
    checkOutput("rst_count",    64'(count),    64'd0);
    checkOutput("rst_stall",    64'(stall),    64'd0);
    checkOutput("rst_overflow", 64'(overflow), 64'd0);
    checkOutput("rst_writereg", 64'(writereg), 64'd0);
    checkOutput("rst_wdata",    writedata,     64'd0);

    // Single ALU push
    readreg1 = 5'd5; readreg2 = 5'd6;
    applyStimulus(1'b0, 5'd0, 64'h0, 1'b1, 5'd5, 64'h1111);
    checkOutput("single_regwrite", 64'(RegWrite), 64'd1);
    checkOutput("single_writereg", 64'(writereg), 64'd5);
    checkOutput("single_wdata",    writedata,     64'h1111);
    checkOutput("single_hit1",     64'(fwd_hit1), 64'd1);
    checkOutput("single_data1",    fwd_data1,     64'h1111);
    checkOutput("single_hit2",     64'(fwd_hit2), 64'd0);
    checkOutput("single_data2",    fwd_data2,     64'd0);
    idle();
    checkOutput("single_count0",   64'(count),    64'd0);
    checkOutput("single_regw0",    64'(RegWrite), 64'd0);
    checkOutput("single_hit1_0",   64'(fwd_hit1), 64'd0);

    // Dual push to the same register
    readreg1 = 5'd3;
    applyStimulus(1'b1, 5'd3, 64'hAA, 1'b1, 5'd3, 64'hBB);
    checkOutput("dual_count",    64'(count),    64'd2);
    checkOutput("dual_wreg",     64'(writereg), 64'd3);
    checkOutput("dual_wdata1",   writedata,     64'hAA);
    checkOutput("dual_fwd_both", fwd_data1,     64'hBB);
    idle();
    checkOutput("dual_count1",   64'(count),    64'd1);
    checkOutput("dual_wdata2",   writedata,     64'hBB);
    checkOutput("dual_hit_one",  64'(fwd_hit1), 64'd1);
    checkOutput("dual_fwd_one",  fwd_data1,     64'hBB);
    idle();
    checkOutput("dual_hit_none", 64'(fwd_hit1), 64'd0);
    checkOutput("dual_count0",   64'(count),    64'd0);

    // Four back-to-back dual pushes; the last one overflows by one entry
    applyStimulus(1'b1, 5'd1, 64'h10, 1'b1, 5'd2, 64'h20);
    checkOutput("burst1_count", 64'(count),    64'd2);
    checkOutput("burst1_stall", 64'(stall),    64'd0);
    checkOutput("burst1_wdata", writedata,     64'h10);
    applyStimulus(1'b1, 5'd3, 64'h30, 1'b1, 5'd4, 64'h40);
    checkOutput("burst2_count", 64'(count),    64'd3);
    checkOutput("burst2_stall", 64'(stall),    64'd1);
    checkOutput("burst2_wdata", writedata,     64'h20);
    applyStimulus(1'b1, 5'd5, 64'h50, 1'b1, 5'd6, 64'h60);
    checkOutput("burst3_count", 64'(count),    64'd4);
    checkOutput("burst3_ovf",   64'(overflow), 64'd0);
    checkOutput("burst3_wreg",  64'(writereg), 64'd3);
    readreg1 = 5'd8; readreg2 = 5'd7;
    applyStimulus(1'b1, 5'd7, 64'h70, 1'b1, 5'd8, 64'h80);
    checkOutput("burst4_count", 64'(count),    64'd4);
    checkOutput("burst4_ovf",   64'(overflow), 64'd1);
    checkOutput("burst4_wdata", writedata,     64'h40);
    checkOutput("burst4_hit8",  64'(fwd_hit1), 64'd0);
    checkOutput("burst4_hit7",  64'(fwd_hit2), 64'd1);
    checkOutput("burst4_data7", fwd_data2,     64'h70);

    // Full queue single push is accepted thanks to the same-edge pop
    applyStimulus(1'b0, 5'd0, 64'h0, 1'b1, 5'd9, 64'h90);
    checkOutput("full_count", 64'(count),    64'd4);
    checkOutput("full_ovf",   64'(overflow), 64'd1);
    checkOutput("full_wdata", writedata,     64'h50);
    idle();
    checkOutput("drain1_wreg",  64'(writereg), 64'd6);
    checkOutput("drain1_wdata", writedata,     64'h60);
    idle();
    checkOutput("drain2_wdata", writedata,     64'h70);
    idle();
    checkOutput("drain3_wreg",  64'(writereg), 64'd9);
    checkOutput("drain3_wdata", writedata,     64'h90);
    idle();
    checkOutput("drain_count0", 64'(count),    64'd0);
    checkOutput("drain_ovf",    64'(overflow), 64'd1);

    // Reset while three entries are pending, with a push on the reset edge
    applyStimulus(1'b1, 5'd10, 64'hA0, 1'b1, 5'd11, 64'hB0);
    applyStimulus(1'b1, 5'd12, 64'hC0, 1'b1, 5'd13, 64'hD0);
    checkOutput("prerst_count", 64'(count), 64'd3);
    readreg1 = 5'd13; readreg2 = 5'd14;
    rst_n = 1'b0;
    applyStimulus(1'b0, 5'd0, 64'h0, 1'b1, 5'd14, 64'hE0);
    rst_n = 1'b1;
    #1;
    checkOutput("midrst_count",    64'(count),    64'd0);
    checkOutput("midrst_regwrite", 64'(RegWrite), 64'd0);
    checkOutput("midrst_hit1",     64'(fwd_hit1), 64'd0);
    checkOutput("midrst_hit2",     64'(fwd_hit2), 64'd0);
    checkOutput("midrst_ovf",      64'(overflow), 64'd0);
    checkOutput("midrst_wreg",     64'(writereg), 64'd0);
    idle();
    checkOutput("postrst_count",   64'(count),    64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
